pistorm_bus_arbiter: RTL and testbench
======================================

Name: pistorm_bus_arbiter

Overview:
- Synchronous 68000 bus-arbitration controller for the PiStorm'X-DMA CPLD.
- Sits between the Pi transaction engine (S2/S3/S4/S7 state machine) and the Amiga BR_n/BG_n/BGACK_n lines.
- Decides, on each M68K_CLK edge, whether the engine may start a bus cycle or must hand the bus to an external DMA master.
- Generates bus_released, which tri-states the engine's address, data, strobe and RW drivers.
- Adds BR/BGACK synchronisation, a grant timeout and a Pi anti-starvation slot.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on BR_n and BGACK_n (2 or 3).
- GRANT_TIMEOUT, 8'd200, clocks BG_n may stay low without BGACK before the grant is withdrawn.
- PI_SLOTS, 2'd1, engine cycles guaranteed to the Pi after an external tenure ends, provided eng_req is pending.

Ports:
- M68K_CLK  input  1  7 MHz bus clock; all state changes on the rising edge.
- M68K_RESET_n  input  1  asynchronous active-low reset.
- M68K_BR_n  input  1  external bus request, asynchronous.
- M68K_BGACK_n  input  1  external bus-grant acknowledge, asynchronous.
- M68K_BG_n  output  1  bus grant to the external master, registered.
- eng_req  input  1  engine has a pending Pi transaction (op_req).
- eng_idle  input  1  engine is in S7 with AS negated.
- eng_start  output  1  one-clock pulse: engine may leave S7 and enter S2.
- bus_released  output  1  1 = engine drivers must be high-Z.
- grant_timeout  output  1  sticky flag: a grant was withdrawn because of timeout.
- clr_timeout  input  1  clears grant_timeout; takes priority over a simultaneous set.

Behaviour:
- Reset values: M68K_BG_n=1, eng_start=0, bus_released=0, grant_timeout=0, state=IDLE, timeout counter=0, slot counter=0, synchronisers all 1 (negated).
- br and bgack are the active-high outputs of the synchroniser. Input-to-decision latency is SYNC_STAGES clocks.

States:
- IDLE: engine idle and bus owned by the Pi.
  - br=1 and pi_slots=0 → GRANT.
  - Else eng_req=1 → pulse eng_start and go to PI_CYCLE.
  - If br=1 and pi_slots>0 while eng_req=1, the Pi cycle wins and pi_slots decrements on eng_start.
  - If eng_req=0, pi_slots is cleared to 0.
- PI_CYCLE: wait for eng_idle=1, then go to IDLE.
  - br is not serviced during this state.
  - No second eng_start is issued while in PI_CYCLE.
- GRANT: BG_n=0 and the counter increments each clock.
  - bgack=1 → EXT_OWNED; BG_n is negated on the same edge.
  - br=0 and bgack=0 → IDLE with BG_n=1 (request withdrawn).
  - Counter reaches GRANT_TIMEOUT → IDLE, BG_n=1, grant_timeout=1.
  - If bgack=1 and the timeout fall on the same edge, bgack wins and no flag is set.
- EXT_OWNED: bus_released=1 and BG_n=1.
  - bgack=0 → RELEASE.
- RELEASE: bus_released stays 1 for exactly one clock so the external drivers turn off. Load pi_slots=PI_SLOTS, then go to IDLE.
  - If br=1 and bgack=1 again, go straight back to EXT_OWNED.

Invariants:
- bus_released=1 only in EXT_OWNED and RELEASE.
- eng_start is never asserted while BG_n=0 or bus_released=1.

Arithmetic:
- Timeout counter is 8 bits, saturating, cleared on entry to GRANT.
- pi_slots is 2 bits, decrements only on eng_start, floor 0.

Mid-operation events:
- An async reset asserted in any state returns to IDLE on the same edge, with BG_n=1 and bus_released=0.
- An external master that has already driven BGACK must see BG negated; it does not rely on the arbiter.

Decomposition:
- Shared package pistorm_pkg holds:
  - State encoding ARB_IDLE, ARB_PI_CYCLE, ARB_GRANT, ARB_EXT_OWNED, ARB_RELEASE (one-hot, 5 bits).
  - Width constants TIMEOUT_W=8 and SLOT_W=2.
- One natural sub-module, pistorm_sync. It is a parameterised SYNC_STAGES flop chain with reset value 1 and is instantiated twice (BR, BGACK).

Test Plan:
- Reset, then eng_req=1 with eng_idle toggling → eng_start pulses once per cycle, BG_n stays 1, bus_released stays 0.
- BR_n low while idle, then BGACK_n low 4 clocks after BG_n falls → BG_n falls SYNC_STAGES+1 clocks after BR_n. BG_n rises on the edge bgack is seen, bus_released=1.
- BR_n low during PI_CYCLE (eng_idle=0 for 6 clocks) → BG_n stays 1 until eng_idle=1, then falls. No eng_start is issued while BG_n=0.
- BR_n low, no BGACK, GRANT_TIMEOUT=200 → BG_n rises after exactly 200 clocks and grant_timeout=1. clr_timeout pulse → grant_timeout=0.
- External tenure ends with eng_req=1 and BR_n still low → one-clock RELEASE, then one eng_start (PI_SLOTS=1) before BG_n falls again.
- Async reset asserted mid-GRANT and mid-EXT_OWNED → BG_n=1, bus_released=0, grant_timeout=0, state=IDLE immediately.

Source files
------------

// File: rtl/pistorm_pkg.sv
// Shared types and helpers for the PiStorm bus arbitration logic.
package pistorm_pkg;

   localparam int TIMEOUT_W = 8;
   localparam int SLOT_W    = 2;

   typedef enum logic [4:0] {
      ARB_IDLE      = 5'b00001,
      ARB_PI_CYCLE  = 5'b00010,
      ARB_GRANT     = 5'b00100,
      ARB_EXT_OWNED = 5'b01000,
      ARB_RELEASE   = 5'b10000
   } arb_state_t;

   // Saturating increment for the grant timeout counter.
   function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
      return (v == {TIMEOUT_W{1'b1}}) ? v : v + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   endfunction

   // Decrement with a floor of zero for the Pi slot counter.
   function automatic logic [SLOT_W-1:0] slot_dec(input logic [SLOT_W-1:0] v);
      return (v == {SLOT_W{1'b0}}) ? v : v - {{(SLOT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/pistorm_sync.sv
// Flop-chain synchroniser for asynchronous active-low bus lines; resets to negated (1).
module pistorm_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_r;

   // Shift the raw input through the synchroniser chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_r <= {STAGES{1'b1}};
      end else begin
         chain_r <= {chain_r[STAGES-2:0], d};
      end
   end

   assign q = chain_r[STAGES-1];

endmodule

// File: rtl/pistorm_bus_arbiter.sv
// 68000 bus arbiter: shares the Amiga bus between the Pi engine and external DMA masters,
// with a grant timeout and a guaranteed Pi slot after each external tenure.
module pistorm_bus_arbiter
   import pistorm_pkg::*;
#(
   parameter int unsigned           SYNC_STAGES   = 2,
   parameter logic [TIMEOUT_W-1:0]  GRANT_TIMEOUT = 8'd200,
   parameter logic [SLOT_W-1:0]     PI_SLOTS      = 2'd1
) (
   input  logic M68K_CLK,
   input  logic M68K_RESET_n,
   input  logic M68K_BR_n,
   input  logic M68K_BGACK_n,
   output logic M68K_BG_n,
   input  logic eng_req,
   input  logic eng_idle,
   output logic eng_start,
   output logic bus_released,
   output logic grant_timeout,
   input  logic clr_timeout
);

   logic br_n_sync_s;
   logic bgack_n_sync_s;
   logic br_s;
   logic bgack_s;

   pistorm_sync #(.STAGES(SYNC_STAGES)) u_br_sync (
      .clk   (M68K_CLK),
      .rst_n (M68K_RESET_n),
      .d     (M68K_BR_n),
      .q     (br_n_sync_s)
   );

   pistorm_sync #(.STAGES(SYNC_STAGES)) u_bgack_sync (
      .clk   (M68K_CLK),
      .rst_n (M68K_RESET_n),
      .d     (M68K_BGACK_n),
      .q     (bgack_n_sync_s)
   );

   assign br_s    = ~br_n_sync_s;
   assign bgack_s = ~bgack_n_sync_s;

   arb_state_t           state_r;
   logic [TIMEOUT_W-1:0] cnt_r;
   logic [TIMEOUT_W-1:0] cnt_inc_s;
   logic [SLOT_W-1:0]    slots_r;
   logic                 bg_n_r;
   logic                 eng_start_r;
   logic                 released_r;
   logic                 timeout_r;
   logic                 grant_expired_s;
   logic                 timeout_set_s;

   assign cnt_inc_s       = sat_inc(cnt_r);
   assign grant_expired_s = (cnt_inc_s >= GRANT_TIMEOUT);
   // A grant only times out if neither acknowledge nor withdrawal happens on that edge.
   assign timeout_set_s   = (state_r == ARB_GRANT) && !bgack_s && br_s && grant_expired_s;

   // Arbitration FSM with registered bus-grant, start and release outputs.
   always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
      if (!M68K_RESET_n) begin
         state_r     <= ARB_IDLE;
         cnt_r       <= {TIMEOUT_W{1'b0}};
         slots_r     <= {SLOT_W{1'b0}};
         bg_n_r      <= 1'b1;
         eng_start_r <= 1'b0;
         released_r  <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         eng_start_r <= 1'b0;

         if (clr_timeout) begin
            timeout_r <= 1'b0;
         end else if (timeout_set_s) begin
            timeout_r <= 1'b1;
         end else begin
            timeout_r <= timeout_r;
         end

         case (state_r)
            ARB_IDLE: begin
               if (br_s && (slots_r == {SLOT_W{1'b0}})) begin
                  state_r <= ARB_GRANT;
                  bg_n_r  <= 1'b0;
                  cnt_r   <= {TIMEOUT_W{1'b0}};
               end else if (eng_req) begin
                  state_r     <= ARB_PI_CYCLE;
                  eng_start_r <= 1'b1;
                  slots_r     <= slot_dec(slots_r);
               end else begin
                  slots_r <= {SLOT_W{1'b0}};
               end
            end
            ARB_PI_CYCLE: begin
               // eng_idle still reflects S7 during the start pulse, so ignore it then.
               if (eng_idle && !eng_start_r) begin
                  state_r <= ARB_IDLE;
               end else begin
                  state_r <= ARB_PI_CYCLE;
               end
            end
            ARB_GRANT: begin
               cnt_r <= cnt_inc_s;
               if (bgack_s) begin
                  state_r    <= ARB_EXT_OWNED;
                  bg_n_r     <= 1'b1;
                  released_r <= 1'b1;
               end else if (!br_s || grant_expired_s) begin
                  state_r <= ARB_IDLE;
                  bg_n_r  <= 1'b1;
               end else begin
                  state_r <= ARB_GRANT;
               end
            end
            ARB_EXT_OWNED: begin
               bg_n_r     <= 1'b1;
               released_r <= 1'b1;
               if (!bgack_s) begin
                  state_r <= ARB_RELEASE;
               end else begin
                  state_r <= ARB_EXT_OWNED;
               end
            end
            ARB_RELEASE: begin
               if (br_s && bgack_s) begin
                  state_r <= ARB_EXT_OWNED;
               end else begin
                  state_r    <= ARB_IDLE;
                  released_r <= 1'b0;
                  slots_r    <= PI_SLOTS;
               end
            end
            default: begin
               state_r    <= ARB_IDLE;
               bg_n_r     <= 1'b1;
               released_r <= 1'b0;
            end
         endcase
      end
   end

   assign M68K_BG_n     = bg_n_r;
   assign eng_start     = eng_start_r;
   assign bus_released  = released_r;
   assign grant_timeout = timeout_r;

endmodule

// File: tb/tb_pistorm_bus_arbiter.sv
// Directed testbench for pistorm_bus_arbiter with hand-computed expected values.
module tb_pistorm_bus_arbiter;

   logic clk;
   logic rst_n;
   logic br_n;
   logic bgack_n;
   logic bg_n;
   logic eng_req;
   logic eng_idle;
   logic eng_start;
   logic bus_released;
   logic grant_timeout;
   logic clr_timeout;

   int checks;
   int errors;
   int n;

   pistorm_bus_arbiter dut (
      .M68K_CLK      (clk),
      .M68K_RESET_n  (rst_n),
      .M68K_BR_n     (br_n),
      .M68K_BGACK_n  (bgack_n),
      .M68K_BG_n     (bg_n),
      .eng_req       (eng_req),
      .eng_idle      (eng_idle),
      .eng_start     (eng_start),
      .bus_released  (bus_released),
      .grant_timeout (grant_timeout),
      .clr_timeout   (clr_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_bg, input logic e_start,
                             input logic e_rel, input logic e_to);
      check({tag, ".bg_n"}, {31'd0, bg_n}, {31'd0, e_bg});
      check({tag, ".start"}, {31'd0, eng_start}, {31'd0, e_start});
      check({tag, ".rel"}, {31'd0, bus_released}, {31'd0, e_rel});
      check({tag, ".to"}, {31'd0, grant_timeout}, {31'd0, e_to});
   endtask

   // Engine busy for 'busy' clocks after a start pulse, then back in S7.
   task automatic run_pi(input int busy);
      eng_idle = 1'b0;
      for (int i = 0; i < busy; i++) begin
         step(1);
         check("pi_busy.start", {31'd0, eng_start}, 32'd0);
      end
      eng_idle = 1'b1;
      step(1);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      br_n        = 1'b1;
      bgack_n     = 1'b1;
      eng_req     = 1'b0;
      eng_idle    = 1'b1;
      clr_timeout = 1'b0;
      step(2);
      check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(1);
      check_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0);

      // Pi cycles back to back
      eng_req = 1'b1;
      step(1);
      check_outs("pi1", 1'b1, 1'b1, 1'b0, 1'b0);
      run_pi(3);
      check_outs("pi1_done", 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      check_outs("pi2", 1'b1, 1'b1, 1'b0, 1'b0);
      eng_req = 1'b0;
      run_pi(2);

      // Grant latency and acknowledge
      br_n = 1'b0;
      step(2);
      check("grant_lat2.bg_n", {31'd0, bg_n}, 32'd1);
      step(1);
      check("grant_lat3.bg_n", {31'd0, bg_n}, 32'd0);
      step(4);
      bgack_n = 1'b0;
      br_n    = 1'b1;
      step(2);
      check("ack_sync.bg_n", {31'd0, bg_n}, 32'd0);
      step(1);
      check_outs("ext", 1'b1, 1'b0, 1'b1, 1'b0);
      bgack_n = 1'b1;
      step(2);
      check("ext_hold.rel", {31'd0, bus_released}, 32'd1);
      step(1);
      check("release.rel", {31'd0, bus_released}, 32'd1);
      step(1);
      check_outs("after_rel", 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);

      // Request during a Pi cycle is deferred
      eng_req = 1'b1;
      step(1);
      check("pc_start", {31'd0, eng_start}, 32'd1);
      eng_req  = 1'b0;
      br_n     = 1'b0;
      eng_idle = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         check("pc_hold.bg_n", {31'd0, bg_n}, 32'd1);
      end
      eng_idle = 1'b1;
      step(1);
      check("pc_end.bg_n", {31'd0, bg_n}, 32'd1);
      step(1);
      check_outs("pc_grant", 1'b0, 1'b0, 1'b0, 1'b0);

      // Withdrawn request
      br_n = 1'b1;
      step(2);
      check("wd_sync.bg_n", {31'd0, bg_n}, 32'd0);
      step(1);
      check_outs("withdrawn", 1'b1, 1'b0, 1'b0, 1'b0);

      // Grant timeout
      br_n = 1'b0;
      step(3);
      check("to_enter.bg_n", {31'd0, bg_n}, 32'd0);
      n = 0;
      while (bg_n == 1'b0 && n < 300) begin
         if (n == 198) br_n = 1'b1;
         step(1);
         n++;
      end
      check("to_len", n, 32'd200);
      check_outs("to_flag", 1'b1, 1'b0, 1'b0, 1'b1);
      step(2);
      check_outs("to_idle", 1'b1, 1'b0, 1'b0, 1'b1);
      clr_timeout = 1'b1;
      step(1);
      clr_timeout = 1'b0;
      check("to_clr", {31'd0, grant_timeout}, 32'd0);

      // Tenure ends with Pi pending and another request
      br_n = 1'b0;
      step(3);
      check("t5_grant.bg_n", {31'd0, bg_n}, 32'd0);
      bgack_n = 1'b0;
      eng_req = 1'b1;
      step(3);
      check_outs("t5_ext", 1'b1, 1'b0, 1'b1, 1'b0);
      bgack_n = 1'b1;
      step(3);
      check_outs("t5_release", 1'b1, 1'b0, 1'b1, 1'b0);
      step(1);
      check_outs("t5_idle", 1'b1, 1'b0, 1'b0, 1'b0);
      step(1);
      check_outs("t5_slot", 1'b1, 1'b1, 1'b0, 1'b0);
      eng_req = 1'b0;
      run_pi(1);
      check("t5_pi_done.bg_n", {31'd0, bg_n}, 32'd1);
      step(1);
      check_outs("t5_regrant", 1'b0, 1'b0, 1'b0, 1'b0);

      // Async reset mid-GRANT
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("rst_grant", 1'b1, 1'b0, 1'b0, 1'b0);
      br_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step(3);
      check("rst_grant_idle.bg_n", {31'd0, bg_n}, 32'd1);

      // Async reset mid-EXT_OWNED
      br_n = 1'b0;
      step(3);
      bgack_n = 1'b0;
      step(3);
      check("pre_rst_ext.rel", {31'd0, bus_released}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("rst_ext", 1'b1, 1'b0, 1'b0, 1'b0);
      br_n    = 1'b1;
      bgack_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step(3);
      check_outs("rst_ext_idle", 1'b1, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
